// File: rtl/sysbus_arb_pkg.sv
// Shared types and constants for the two-requester Sysbus arbiter.
package sysbus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WDATA,
        ST_RESP
    } arb_state_t;

    localparam int FETCH = 0;
    localparam int DATA  = 1;

    // Tag layout: {write, type[3:0], id[7:0]}
    localparam int TAG_W_DEF     = 13;
    localparam int TAG_WRITE_BIT = 12;
    localparam int TAG_TYPE_MSB  = 11;
    localparam int TAG_TYPE_LSB  = 8;
    localparam int TAG_ID_MSB    = 7;
    localparam int TAG_ID_LSB    = 0;

endpackage

// File: rtl/arb_pick2.sv
// Two-way request picker: the requester named by ptr wins when it asks,
// otherwise the other one. Grant is one-hot, or zero when nobody asks.
module arb_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    logic other;

    assign other = ~ptr;

    always_comb begin
        grant = 2'b00;
        if (req[ptr]) begin
            grant[ptr] = 1'b1;
        end else if (req[other]) begin
            grant[other] = 1'b1;
        end
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// Arbitrates the fetch and data requesters onto a single Sysbus channel, one
// line transaction at a time. Define SYSBUS_ARB_RR_EN for round-robin; default is fixed data-first priority.
module sysbus_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int LINE_BEATS = 8,
    parameter int TAG_W      = TAG_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            r_reqcyc,
    input  logic [1:0][63:0]      r_req,
    input  logic [1:0][TAG_W-1:0] r_reqtag,
    output logic [1:0]            r_reqack,
    output logic [1:0]            r_respcyc,
    output logic [63:0]           r_resp,
    output logic [TAG_W-1:0]      r_resptag,
    input  logic [1:0]            r_respack,
    output logic                  bus_reqcyc,
    output logic [63:0]           bus_req,
    output logic [TAG_W-1:0]      bus_reqtag,
    input  logic                  bus_reqack,
    input  logic                  bus_respcyc,
    input  logic [63:0]           bus_resp,
    input  logic [TAG_W-1:0]      bus_resptag,
    output logic                  bus_respack
);

    localparam logic [3:0] LAST_BEAT = 4'(LINE_BEATS - 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             winner;
    logic [63:0]      addr_q;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]       beat_cnt;
    logic             tag_err;
    logic [1:0]       grant;
    logic             pick_ptr;
    logic             last_beat;
    logic             beat_ack;
    logic             id_mismatch;

`ifdef SYSBUS_ARB_RR_EN
    logic ptr;
    assign pick_ptr = ptr;
`else
    assign pick_ptr = 1'(DATA);
`endif

    arb_pick2 u_pick (
        .req   (r_reqcyc),
        .ptr   (pick_ptr),
        .grant (grant)
    );

    assign last_beat   = (beat_cnt == LAST_BEAT);
    assign beat_ack    = (state == ST_RESP) && bus_respcyc && bus_respack;
    assign id_mismatch = (bus_resptag[TAG_ID_MSB:TAG_ID_LSB] != tag_q[TAG_ID_MSB:TAG_ID_LSB]);
    assign bus_reqtag  = tag_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        r_reqack    = 2'b00;
        r_respcyc   = 2'b00;
        r_resp      = '0;
        r_resptag   = '0;
        bus_respack = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_req     = addr_q;
        case (state)
            ST_IDLE: begin
                if (|grant) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                bus_reqcyc = 1'b1;
                if (bus_reqack) begin
                    r_reqack[winner] = 1'b1;
                    state_nxt = tag_q[TAG_WRITE_BIT] ? ST_WDATA : ST_RESP;
                end
            end
            ST_WDATA: begin
                // Requester streams one data word per cycle straight onto the bus
                bus_reqcyc = 1'b1;
                bus_req    = r_req[winner];
                if (last_beat) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RESP: begin
                r_respcyc[winner] = bus_respcyc;
                r_resp            = bus_resp;
                r_resptag         = bus_resptag;
                bus_respack       = r_respack[winner];
                if (beat_ack && last_beat) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            winner   <= 1'b0;
            addr_q   <= '0;
            tag_q    <= '0;
            beat_cnt <= '0;
            tag_err  <= 1'b0;
`ifdef SYSBUS_ARB_RR_EN
            ptr      <= 1'(FETCH);
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        winner   <= grant[DATA];
                        addr_q   <= r_req[grant[DATA]];
                        tag_q    <= r_reqtag[grant[DATA]];
                        beat_cnt <= '0;
`ifdef SYSBUS_ARB_RR_EN
                        ptr      <= ~grant[DATA];
`endif
                    end
                end
                ST_WDATA: begin
                    beat_cnt <= last_beat ? 4'd0 : beat_cnt + 4'd1;
                end
                ST_RESP: begin
                    if (beat_ack) begin
                        beat_cnt <= last_beat ? 4'd0 : beat_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
            // Mismatched beats are still forwarded; the flag only records that it happened
            tag_err <= tag_err | ((state == ST_RESP) && bus_respcyc && id_mismatch);
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Self-checking bench for sysbus_arbiter: transaction-level model plus
// directed scenarios and a randomized phase.
module tb_sysbus_arbiter;

    localparam int LB = 8;
    localparam int TW = 13;
`ifdef SYSBUS_ARB_RR_EN
    localparam int FIRST_PREF = 0;
`else
    localparam int FIRST_PREF = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_n;
    logic [1:0]          r_reqcyc;
    logic [1:0][63:0]    r_req;
    logic [1:0][TW-1:0]  r_reqtag;
    logic [1:0]          r_reqack;
    logic [1:0]          r_respcyc;
    logic [63:0]         r_resp;
    logic [TW-1:0]       r_resptag;
    logic [1:0]          r_respack;
    logic                bus_reqcyc;
    logic [63:0]         bus_req;
    logic [TW-1:0]       bus_reqtag;
    logic                bus_reqack;
    logic                bus_respcyc;
    logic [63:0]         bus_resp;
    logic [TW-1:0]       bus_resptag;
    logic                bus_respack;

    sysbus_arbiter #(.LINE_BEATS(LB), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n),
        .r_reqcyc(r_reqcyc), .r_req(r_req), .r_reqtag(r_reqtag), .r_reqack(r_reqack),
        .r_respcyc(r_respcyc), .r_resp(r_resp), .r_resptag(r_resptag), .r_respack(r_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Reference model: one outstanding transaction record
    bit            m_busy, m_acked, m_write, m_tag_err;
    int            m_who, m_beats, m_pref;
    logic [63:0]   m_addr;
    logic [TW-1:0] m_tag;
    int            grant_log[$];

    function automatic int pick(logic [1:0] req, int pref);
        return req[pref] ? pref : 1 - pref;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 0; m_acked <= 0; m_write <= 0; m_tag_err <= 0;
            m_who <= 0; m_beats <= 0; m_addr <= '0; m_tag <= '0;
            m_pref <= FIRST_PREF;
        end else if (!m_busy) begin
            if (r_reqcyc != 2'b00) begin
                m_busy  <= 1;
                m_acked <= 0;
                m_beats <= 0;
                m_who   <= pick(r_reqcyc, m_pref);
                m_addr  <= r_req[pick(r_reqcyc, m_pref)];
                m_tag   <= r_reqtag[pick(r_reqcyc, m_pref)];
                grant_log.push_back(pick(r_reqcyc, m_pref));
`ifdef SYSBUS_ARB_RR_EN
                m_pref  <= 1 - pick(r_reqcyc, m_pref);
`endif
            end
        end else if (!m_acked) begin
            if (bus_reqack) begin
                m_acked <= 1;
                m_write <= m_tag[12];
            end
        end else if (m_write) begin
            m_beats <= m_beats + 1;
            if (m_beats == LB - 1) m_busy <= 0;
        end else begin
            if (bus_respcyc && bus_resptag[7:0] != m_tag[7:0]) m_tag_err <= 1;
            if (bus_respcyc && r_respack[m_who]) begin
                m_beats <= m_beats + 1;
                if (m_beats == LB - 1) m_busy <= 0;
            end
        end
    end

    task automatic compare_cycle();
        logic       ph_addr, ph_wr, ph_rd, e_respack;
        logic [1:0] e_reqack, e_respcyc;
        if (!reset_n) return;
        ph_addr   = m_busy && !m_acked;
        ph_wr     = m_busy && m_acked && m_write;
        ph_rd     = m_busy && m_acked && !m_write;
        e_reqack  = 2'b00;
        e_respcyc = 2'b00;
        e_respack = 1'b0;
        if (ph_addr && bus_reqack) e_reqack[m_who] = 1'b1;
        if (ph_rd) begin
            e_respcyc[m_who] = bus_respcyc;
            e_respack        = r_respack[m_who];
        end
        check("bus_reqcyc", bus_reqcyc, ph_addr || ph_wr);
        check("r_reqack", r_reqack, e_reqack);
        check("r_respcyc", r_respcyc, e_respcyc);
        check("bus_respack", bus_respack, e_respack);
        check("tag_err", dut.tag_err, m_tag_err);
        if (ph_addr) begin
            check("addr_bus_req", bus_req, m_addr);
            check("addr_bus_reqtag", bus_reqtag, m_tag);
        end
        if (ph_wr) begin
            check("wdata_bus_req", bus_req, m_addr + 64'(m_beats) + 64'd1);
            check("wdata_bus_reqtag", bus_reqtag, m_tag);
        end
        if (ph_rd) begin
            check("r_resp", r_resp, bus_resp);
            check("r_resptag", r_resptag, bus_resptag);
        end
    endtask

    always @(negedge clk) compare_cycle();

    // Requester agents, bench-side bus slave and observation counters
    int            a_st[2];
    int            a_k[2];
    bit            a_write[2];
    logic [63:0]   a_addr[2];
    bit            rand_mode, stall_en;
    int            stall_n;
    logic [7:0]    mis_mask;
    int            c_ack[2], c_resp[2], c_beat[2];
    int            c_stall, total_acks;
    int            ack_order[$];
    logic [63:0]   busq[$];

    task automatic clear_obs();
        for (int i = 0; i < 2; i++) begin
            c_ack[i] = 0; c_resp[i] = 0; c_beat[i] = 0;
        end
        c_stall = 0;
        ack_order.delete();
        busq.delete();
    endtask

    task automatic start_req(int i, logic [63:0] addr, logic [TW-1:0] tag);
        r_reqcyc[i] = 1'b1;
        r_req[i]    = addr;
        r_reqtag[i] = tag;
        a_st[i]     = 1;
        a_addr[i]   = addr;
        a_write[i]  = tag[12];
    endtask

    task automatic tick();
        logic [1:0] ack_seen;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            ack_seen[i] = r_reqack[i];
            if (r_reqack[i]) begin
                c_ack[i]++;
                total_acks++;
                ack_order.push_back(i);
            end
            if (r_respcyc[i]) c_resp[i]++;
            if (r_respcyc[i] && r_respack[i]) c_beat[i]++;
        end
        if (bus_reqcyc) busq.push_back(bus_req);
        if (r_respcyc[0] && !bus_respack) c_stall++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (a_st[i] == 2) begin
                a_k[i]++;
                if (a_k[i] == LB) a_st[i] = 0;
                else r_req[i] = a_addr[i] + 64'(a_k[i]) + 64'd1;
            end else if (a_st[i] == 1 && ack_seen[i]) begin
                r_reqcyc[i] = 1'b0;
                if (a_write[i]) begin
                    a_st[i]  = 2;
                    a_k[i]   = 0;
                    r_req[i] = a_addr[i] + 64'd1;
                end else begin
                    a_st[i] = 0;
                end
            end
        end
        if (rand_mode) begin
            bus_reqack  = ($urandom_range(0, 2) == 0);
            bus_respcyc = ($urandom_range(0, 1) == 1);
            bus_resp    = {$urandom, $urandom};
            bus_resptag = {m_tag[12:8] ^ 5'($urandom),
                           m_tag[7:0] ^ (($urandom_range(0, 49) == 0) ? 8'h5A : 8'h00)};
            r_respack   = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
        end else begin
            bus_reqack  = 1'b1;
            bus_respcyc = 1'b1;
            bus_resp    = bus_resp + 64'd1;
            bus_resptag = {m_tag[12:8], m_tag[7:0] ^ mis_mask};
            r_respack   = 2'b11;
            if (stall_en && c_beat[0] == 3 && stall_n < 3) begin
                r_respack[0] = 1'b0;
                stall_n++;
            end
        end
    endtask

    task automatic drain(int budget);
        int  n;
        bit  busy;
        n = 0;
        do begin
            tick();
            n++;
            busy = m_busy || a_st[0] != 0 || a_st[1] != 0;
        end while (busy && n < budget);
        check("drain_timeout", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_first;
        int n;
        reset_n = 1'b0;
        r_reqcyc = 2'b00; r_req = '0; r_reqtag = '0; r_respack = 2'b11;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        rand_mode = 0; stall_en = 0; stall_n = 0; mis_mask = 8'h00; total_acks = 0;
        for (int i = 0; i < 2; i++) begin
            a_st[i] = 0; a_k[i] = 0; a_write[i] = 0; a_addr[i] = '0;
        end
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_reqcyc", bus_reqcyc, 0);
        check("rst_r_reqack", r_reqack, 0);
        check("rst_r_respcyc", r_respcyc, 0);
        check("rst_bus_respack", bus_respack, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_reqtag", bus_reqtag, 0);
        check("rst_tag_err", dut.tag_err, 0);
        reset_n = 1'b1;
        bus_reqack = 1'b1; bus_respcyc = 1'b1;

        // Simultaneous requests from both requesters
`ifdef SYSBUS_ARB_RR_EN
        exp_first = 0;
`else
        exp_first = 1;
`endif
        clear_obs();
        start_req(0, 64'h2000, 13'h0021);
        start_req(1, 64'h3000, 13'h0031);
        drain(120);
        check("both_ack_count", ack_order.size(), 2);
        check("both_first", ack_order[0], exp_first);
        check("both_second", ack_order[1], 1 - exp_first);
        check("both_model_first", grant_log[0], exp_first);
        check("both_beats_fetch", c_resp[0], LB);
        check("both_beats_data", c_resp[1], LB);

        // Fetch-only read
        clear_obs();
        start_req(0, 64'h1000, 13'h0011);
        drain(60);
        check("fetch_busreq_cycles", busq.size(), 1);
        check("fetch_bus_addr", busq[0], 64'h1000);
        check("fetch_ack0", c_ack[0], 1);
        check("fetch_ack1", c_ack[1], 0);
        check("fetch_resp0", c_resp[0], 8);
        check("fetch_resp1", c_resp[1], 0);

        // Data write: all-ones address makes the data words 0..7
        clear_obs();
        start_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 13'h1042);
        drain(60);
        check("write_reqcyc_cycles", busq.size(), 9);
        check("write_ack1", c_ack[1], 1);
        for (int k = 0; k < 8; k++) check("write_word", busq[k + 1], 64'(k));

        // Requester stalls the response for three cycles
        clear_obs();
        stall_en = 1; stall_n = 0;
        start_req(0, 64'h4000, 13'h0055);
        drain(60);
        stall_en = 0;
        check("stall_respack_low", c_stall, 3);
        check("stall_beats_acked", c_beat[0], 8);
        check("stall_resp_cycles", c_resp[0], 11);

        // Response id mismatch
        check("tagerr_before", dut.tag_err, 0);
        clear_obs();
        mis_mask = 8'hFF;
        start_req(0, 64'h5000, 13'h0066);
        drain(60);
        mis_mask = 8'h00;
        check("tagerr_forwarded", c_resp[0], 8);
        check("tagerr_set", dut.tag_err, 1);

        // Reset during the fourth beat of a read
        clear_obs();
        start_req(0, 64'h6000, 13'h0077);
        n = 0;
        while (c_beat[0] < 3 && n < 40) begin
            tick();
            n++;
        end
        check("midrst_in_beat4", r_respcyc, 2'b01);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_bus_reqcyc", bus_reqcyc, 0);
        check("midrst_r_reqack", r_reqack, 0);
        check("midrst_r_respcyc", r_respcyc, 0);
        check("midrst_bus_respack", bus_respack, 0);
        check("midrst_bus_req", bus_req, 0);
        check("midrst_tag_err", dut.tag_err, 0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) a_st[i] = 0;
        r_reqcyc = 2'b00;
        reset_n = 1'b1;
        clear_obs();
        start_req(0, 64'h7000, 13'h0078);
        drain(60);
        check("after_rst_ack", c_ack[0], 1);
        check("after_rst_beats", c_resp[0], 8);

        // Randomized traffic
        rand_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (a_st[i] == 0 && $urandom_range(0, 3) == 0)
                    start_req(i, {$urandom, $urandom},
                              {1'($urandom), 4'($urandom), 8'($urandom)});
            end
        end
        rand_mode = 0;
        drain(400);
        check("grants_vs_acks", grant_log.size(), total_acks);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sysbus_arbiter.md
SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

Interface
REQ-001 Parameter LINE_BEATS, default 8: 64-bit beats per line transfer, both read response and write data.
REQ-002 Parameter TAG_W, default 13: tag width; layout {write[12], type[11:8], id[7:0]}.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 r_reqcyc  in  2  per-requester request valid; index 0 = fetch, 1 = data.
REQ-006 r_req  in  2x64  per-requester address, then write data beats.
REQ-007 r_reqtag  in  2xTAG_W  per-requester request tag.
REQ-008 r_reqack  out  2  per-requester acceptance pulse.
REQ-009 r_respcyc  out  2  per-requester response beat valid.
REQ-010 r_resp / r_resptag  out  64 / TAG_W  response beat and tag, broadcast to both requesters.
REQ-011 r_respack  in  2  per-requester response beat acknowledge.
REQ-012 bus_reqcyc, bus_req, bus_reqtag  out  1, 64, TAG_W  shared Sysbus request channel.
REQ-013 bus_reqack  in  1  Sysbus acceptance.
REQ-014 bus_respcyc, bus_resp, bus_resptag  in  1, 64, TAG_W  Sysbus response.
REQ-015 bus_respack  out  1  Sysbus response acknowledge.

Function
REQ-016 States: IDLE, REQ (address held on bus), WDATA (write beats), RESP (awaiting/forwarding read beats).
REQ-017 IDLE: if any r_reqcyc is high, select a winner, register its req/reqtag onto the bus, set bus_reqcyc next cycle, and go to REQ.
REQ-018 REQ: hold bus_* stable until bus_reqack; in the ack cycle pulse r_reqack[winner] for exactly one cycle and drop bus_reqcyc next cycle.
REQ-019 After ack: write tag (bit 12 = 1) goes to WDATA; read goes to RESP.
REQ-020 WDATA: drive r_req[winner] onto bus_req with bus_reqcyc high for LINE_BEATS consecutive cycles, then return to IDLE.
REQ-021 RESP: route each bus_respcyc beat to r_respcyc[winner], combinationally; bus_respack = r_respack[winner].
REQ-022 RESP: count acknowledged beats with a 4-bit counter; return to IDLE on the LINE_BEATS-th acknowledged beat.
REQ-023 A response beat whose resptag[7:0] differs from the winner's reqtag[7:0] is still forwarded, and a sticky tag_err flag is set for simulation assertion.
REQ-024 Exactly one transaction is outstanding at any time; a requester that loses arbitration keeps r_reqcyc high and is not acked.
REQ-025 Requests seen in the cycle of return to IDLE are arbitrated the following cycle, giving minimum 1 idle cycle between transactions.
REQ-026 No r_reqack occurs outside REQ; no r_respcyc occurs outside RESP.
REQ-027 A requester dropping r_reqcyc before ack is ignored: the winner stays locked until its transaction completes.

Reset
REQ-028 On reset_n low: state IDLE, all *cyc/*ack outputs 0, bus_req/bus_reqtag 0, beat counter 0, priority pointer to fetch, tag_err 0.
REQ-029 Reset asserted mid-transaction aborts it immediately, with no further beats forwarded or acks issued.

Configuration
REQ-030 SYSBUS_ARB_RR_EN defined: round-robin, where the pointer moves to the other requester after each granted transaction.
REQ-031 SYSBUS_ARB_RR_EN undefined: fixed priority, with data (index 1) always beating fetch; the pointer is removed.

Structure
REQ-032 Package sysbus_arb_pkg: state enum, requester index constants FETCH = 0 and DATA = 1, tag field positions, TAG_W default.
REQ-033 One sub-module, arb_pick2: combinational two-way picker from the request vector and pointer, returning the one-hot grant.

Verification
REQ-034 Fetch-only read at 0x1000 -> one bus request addr 0x1000, r_reqack[0] one pulse, 8 beats on r_respcyc[0], r_respcyc[1] never high.
REQ-035 Both request in the same cycle, RR_EN -> fetch first, then data; without RR_EN -> data first, then fetch.
REQ-036 Data write, tag bit 12 = 1 -> bus_reqcyc high 1 + 8 cycles; data words 0..7 appear in order on bus_req.
REQ-037 r_respack[0] held low for 3 cycles mid-burst -> bus_respack low for those cycles and beat count unchanged; completion after the 8th ack.
REQ-038 reset_n pulled low during beat 4 of a read -> all outputs 0 asynchronously; a new request after release is served normally.
REQ-039 Response with a mismatched id -> beat forwarded and tag_err set.
